// File: rtl/boc_corr_accum.sv
// Integrate-and-dump correlator: wipes the BOC/PRN replica off I/Q samples and
// accumulates over an integer number of code periods framed by the generator's sop pulse.
module boc_corr_accum #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                         rx_clk,
    input  logic                         rx_rst,
    input  logic                         rx_corr_en,
    input  logic                         rx_boc_sel,
    input  logic [LEN_WIDTH-1:0]         rx_int_len,
    input  logic signed [DATA_WIDTH-1:0] rx_i_data,
    input  logic signed [DATA_WIDTH-1:0] rx_q_data,
    input  logic                         rx_loc_boc,
    input  logic                         rx_loc_prn,
    input  logic                         rx_prn_sop,
    input  logic                         rx_prn_eop,
    output logic signed [ACC_WIDTH-1:0]  tx_i_acc,
    output logic signed [ACC_WIDTH-1:0]  tx_q_acc,
    output logic                         tx_acc_valid,
    output logic                         tx_acc_ovf,
    output logic                         tx_seq_err,
    output logic [15:0]                  tx_dump_cnt
);

    localparam int PW = DATA_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOP = 2'd1,
        ACCUM    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_inph_q, acc_inph_d;
    logic [ACC_WIDTH-1:0]   acc_quad_q, acc_quad_d;
    logic [ACC_WIDTH-1:0]   dump_inph_q, dump_inph_d;
    logic [ACC_WIDTH-1:0]   dump_quad_q, dump_quad_d;
    logic [LEN_WIDTH-1:0]   period_cnt_q, period_cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   eop_seen_q, eop_seen_d;
    logic                   ovf_q, ovf_d;
    logic                   dump_ovf_q, dump_ovf_d;
    logic                   valid_q, valid_d;
    logic [15:0]            dump_cnt_q, dump_cnt_d;
    logic                   seq_err_q, seq_err_d;

    logic                   replica;
    logic [PW-1:0]          i_ext, q_ext, prod_i, prod_q;
    logic [ACC_WIDTH-1:0]   prod_i_acc, prod_q_acc;
    logic [ACC_WIDTH:0]     sum_i, sum_q;
    logic [ACC_WIDTH-1:0]   sat_i, sat_q;
    logic                   sat_hit_i, sat_hit_q;
    logic [LEN_WIDTH-1:0]   len_eff;
    logic                   is_dump;

    // One extra bit before negation so that -(-2^(DATA_WIDTH-1)) stays positive.
    assign replica    = rx_boc_sel ? rx_loc_boc : rx_loc_prn;
    assign i_ext      = {rx_i_data[DATA_WIDTH-1], rx_i_data};
    assign q_ext      = {rx_q_data[DATA_WIDTH-1], rx_q_data};
    assign prod_i     = replica ? (~i_ext + PW'(1)) : i_ext;
    assign prod_q     = replica ? (~q_ext + PW'(1)) : q_ext;
    assign prod_i_acc = {{(ACC_WIDTH-PW){prod_i[PW-1]}}, prod_i};
    assign prod_q_acc = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};

    assign sum_i      = {acc_inph_q[ACC_WIDTH-1], acc_inph_q} + {prod_i_acc[ACC_WIDTH-1], prod_i_acc};
    assign sum_q      = {acc_quad_q[ACC_WIDTH-1], acc_quad_q} + {prod_q_acc[ACC_WIDTH-1], prod_q_acc};
    assign sat_hit_i  = sum_i[ACC_WIDTH] ^ sum_i[ACC_WIDTH-1];
    assign sat_hit_q  = sum_q[ACC_WIDTH] ^ sum_q[ACC_WIDTH-1];
    assign sat_i      = sat_hit_i ? (sum_i[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_i[ACC_WIDTH-1:0];
    assign sat_q      = sat_hit_q ? (sum_q[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_q[ACC_WIDTH-1:0];

    assign len_eff    = (rx_int_len == '0) ? LEN_WIDTH'(1) : rx_int_len;
    assign is_dump    = rx_prn_sop && (period_cnt_q >= len_q);

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            state_q      <= IDLE;
            acc_inph_q   <= '0;
            acc_quad_q   <= '0;
            dump_inph_q  <= '0;
            dump_quad_q  <= '0;
            period_cnt_q <= '0;
            len_q        <= '0;
            eop_seen_q   <= 1'b0;
            ovf_q        <= 1'b0;
            dump_ovf_q   <= 1'b0;
            valid_q      <= 1'b0;
            dump_cnt_q   <= '0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_inph_q   <= acc_inph_d;
            acc_quad_q   <= acc_quad_d;
            dump_inph_q  <= dump_inph_d;
            dump_quad_q  <= dump_quad_d;
            period_cnt_q <= period_cnt_d;
            len_q        <= len_d;
            eop_seen_q   <= eop_seen_d;
            ovf_q        <= ovf_d;
            dump_ovf_q   <= dump_ovf_d;
            valid_q      <= valid_d;
            dump_cnt_q   <= dump_cnt_d;
            seq_err_q    <= seq_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!rx_corr_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     state_d = WAIT_SOP;
                WAIT_SOP: if (rx_prn_sop) state_d = ACCUM;
                ACCUM:    state_d = ACCUM;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Dump edge: the sop-cycle product seeds the next integration, never the dumped one.
    always_comb begin
        acc_inph_d   = acc_inph_q;
        acc_quad_d   = acc_quad_q;
        dump_inph_d  = dump_inph_q;
        dump_quad_d  = dump_quad_q;
        period_cnt_d = period_cnt_q;
        len_d        = len_q;
        eop_seen_d   = eop_seen_q;
        ovf_d        = ovf_q;
        dump_ovf_d   = dump_ovf_q;
        valid_d      = 1'b0;
        dump_cnt_d   = dump_cnt_q;
        seq_err_d    = seq_err_q;

        if (!rx_corr_en) begin
            acc_inph_d   = '0;
            acc_quad_d   = '0;
            period_cnt_d = '0;
            eop_seen_d   = 1'b0;
            ovf_d        = 1'b0;
            dump_cnt_d   = '0;
            seq_err_d    = 1'b0;
        end else begin
            case (state_q)
                WAIT_SOP: begin
                    if (rx_prn_sop) begin
                        acc_inph_d   = prod_i_acc;
                        acc_quad_d   = prod_q_acc;
                        period_cnt_d = LEN_WIDTH'(1);
                        len_d        = len_eff;
                        eop_seen_d   = 1'b0;
                        ovf_d        = 1'b0;
                    end
                end
                ACCUM: begin
                    if (rx_prn_sop) begin
                        seq_err_d  = seq_err_q | ~(eop_seen_q | rx_prn_eop);
                        eop_seen_d = 1'b0;
                        if (is_dump) begin
                            dump_inph_d  = acc_inph_q;
                            dump_quad_d  = acc_quad_q;
                            dump_ovf_d   = ovf_q;
                            valid_d      = 1'b1;
                            dump_cnt_d   = dump_cnt_q + 16'd1;
                            acc_inph_d   = prod_i_acc;
                            acc_quad_d   = prod_q_acc;
                            period_cnt_d = LEN_WIDTH'(1);
                            len_d        = len_eff;
                            ovf_d        = 1'b0;
                        end else begin
                            acc_inph_d   = sat_i;
                            acc_quad_d   = sat_q;
                            ovf_d        = ovf_q | sat_hit_i | sat_hit_q;
                            period_cnt_d = period_cnt_q + LEN_WIDTH'(1);
                        end
                    end else begin
                        acc_inph_d = sat_i;
                        acc_quad_d = sat_q;
                        ovf_d      = ovf_q | sat_hit_i | sat_hit_q;
                        eop_seen_d = eop_seen_q | rx_prn_eop;
                    end
                end
                default: begin
                    acc_inph_d = '0;
                    acc_quad_d = '0;
                end
            endcase
        end
    end

    assign tx_i_acc     = dump_inph_q;
    assign tx_q_acc     = dump_quad_q;
    assign tx_acc_valid = valid_q;
    assign tx_acc_ovf   = dump_ovf_q;
    assign tx_seq_err   = seq_err_q;
    assign tx_dump_cnt  = dump_cnt_q;

endmodule

// File: tb/tb_boc_corr_accum.sv
// Randomised bench for boc_corr_accum: a queue-based reference model sums each
// integration's wiped samples from scratch at every dump and is compared every cycle.
module tb_boc_corr_accum;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LW = 5;
    localparam int ACC_MAXV = (1 << (AW - 1)) - 1;
    localparam int ACC_MINV = -(1 << (AW - 1));

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  rx_corr_en;
    logic                  rx_boc_sel;
    logic [LW-1:0]         rx_int_len;
    logic signed [DW-1:0]  rx_i_data;
    logic signed [DW-1:0]  rx_q_data;
    logic                  rx_loc_boc;
    logic                  rx_loc_prn;
    logic                  rx_prn_sop;
    logic                  rx_prn_eop;
    logic signed [AW-1:0]  tx_i_acc;
    logic signed [AW-1:0]  tx_q_acc;
    logic                  tx_acc_valid;
    logic                  tx_acc_ovf;
    logic                  tx_seq_err;
    logic [15:0]           tx_dump_cnt;

    boc_corr_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .rx_clk       (clk),
        .rx_rst       (rst_n),
        .rx_corr_en   (rx_corr_en),
        .rx_boc_sel   (rx_boc_sel),
        .rx_int_len   (rx_int_len),
        .rx_i_data    (rx_i_data),
        .rx_q_data    (rx_q_data),
        .rx_loc_boc   (rx_loc_boc),
        .rx_loc_prn   (rx_loc_prn),
        .rx_prn_sop   (rx_prn_sop),
        .rx_prn_eop   (rx_prn_eop),
        .tx_i_acc     (tx_i_acc),
        .tx_q_acc     (tx_q_acc),
        .tx_acc_valid (tx_acc_valid),
        .tx_acc_ovf   (tx_acc_ovf),
        .tx_seq_err   (tx_seq_err),
        .tx_dump_cnt  (tx_dump_cnt)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Stimulus shaping knobs
    bit useConst;
    int constI, constQ;
    int prnMode;
    bit prnTog;
    bit bocFollowsPrn;
    bit bocSelRand;
    bit enJitter;

    // Reference model state: 0 idle, 1 waiting for sop, 2 integrating
    int mState;
    int qI[$];
    int qQ[$];
    int mPeriods, mLen;
    bit mEopSeen;
    int eI, eQ, eCnt;
    bit eOvf, eValid, eErr;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        mState = 0; qI.delete(); qQ.delete();
        mPeriods = 0; mLen = 0; mEopSeen = 0;
        eI = 0; eQ = 0; eCnt = 0; eOvf = 0; eValid = 0; eErr = 0;
    endfunction

    function automatic int satSum(ref int q[$], inout bit hit);
        int s = 0;
        foreach (q[k]) begin
            s += q[k];
            if (s > ACC_MAXV) begin s = ACC_MAXV; hit = 1; end
            else if (s < ACC_MINV) begin s = ACC_MINV; hit = 1; end
        end
        return s;
    endfunction

    function automatic void modelStep();
        bit r;
        int pI, pQ, lenNow;
        bit hit;
        r  = rx_boc_sel ? rx_loc_boc : rx_loc_prn;
        pI = r ? -int'(rx_i_data) : int'(rx_i_data);
        pQ = r ? -int'(rx_q_data) : int'(rx_q_data);
        lenNow = (rx_int_len == 0) ? 1 : int'(rx_int_len);
        eValid = 0;
        if (!rx_corr_en) begin
            mState = 0; qI.delete(); qQ.delete();
            eCnt = 0; eErr = 0;
        end else if (mState == 0) begin
            mState = 1;
        end else if (mState == 1) begin
            if (rx_prn_sop) begin
                qI = '{pI}; qQ = '{pQ};
                mPeriods = 1; mLen = lenNow; mEopSeen = 0; mState = 2;
            end
        end else if (rx_prn_sop) begin
            if (!(mEopSeen || rx_prn_eop)) eErr = 1;
            mEopSeen = 0;
            if (mPeriods < mLen) begin
                qI.push_back(pI); qQ.push_back(pQ);
                mPeriods++;
            end else begin
                hit = 0;
                eI = satSum(qI, hit);
                eQ = satSum(qQ, hit);
                eOvf = hit; eValid = 1;
                eCnt = (eCnt + 1) & 16'hFFFF;
                qI = '{pI}; qQ = '{pQ};
                mPeriods = 1; mLen = lenNow;
            end
        end else begin
            qI.push_back(pI); qQ.push_back(pQ);
            if (rx_prn_eop) mEopSeen = 1;
        end
    endfunction

    task automatic checkAll();
        checkOutput("valid",    int'(tx_acc_valid), int'(eValid));
        checkOutput("i_acc",    int'(tx_i_acc),     eI);
        checkOutput("q_acc",    int'(tx_q_acc),     eQ);
        checkOutput("ovf",      int'(tx_acc_ovf),   int'(eOvf));
        checkOutput("seq_err",  int'(tx_seq_err),   int'(eErr));
        checkOutput("dump_cnt", int'(tx_dump_cnt),  eCnt);
    endtask

    // Called at a negedge: drives one cycle of inputs, steps the model, checks after the posedge.
    task automatic applyStimulus(input bit sop, input bit eop);
        rx_i_data  = useConst ? DW'(constI) : DW'($urandom);
        rx_q_data  = useConst ? DW'(constQ) : DW'($urandom);
        case (prnMode)
            0:       rx_loc_prn = 1'b0;
            1:       begin rx_loc_prn = prnTog; prnTog = ~prnTog; end
            default: rx_loc_prn = 1'($urandom);
        endcase
        rx_loc_boc = bocFollowsPrn ? ~rx_loc_prn : 1'($urandom);
        if (bocSelRand) rx_boc_sel = 1'($urandom);
        if (enJitter) rx_corr_en = ($urandom_range(0, 299) != 0);
        rx_prn_sop = sop;
        rx_prn_eop = eop;
        modelStep();
        @(negedge clk);
        checkAll();
    endtask

    task automatic runPeriod(input int n, input bit dropEop);
        for (int c = 0; c < n; c++)
            applyStimulus(c == 0, (c == n - 1) && !dropEop);
    endtask

    task automatic resetChecks(input string tag);
        checkOutput({tag, "_i"},     int'(tx_i_acc), 0);
        checkOutput({tag, "_q"},     int'(tx_q_acc), 0);
        checkOutput({tag, "_valid"}, int'(tx_acc_valid), 0);
        checkOutput({tag, "_ovf"},   int'(tx_acc_ovf), 0);
        checkOutput({tag, "_err"},   int'(tx_seq_err), 0);
        checkOutput({tag, "_cnt"},   int'(tx_dump_cnt), 0);
    endtask

    initial begin
        rst_n = 1'b0; rx_corr_en = 1'b0; rx_boc_sel = 1'b0; rx_int_len = LW'(1);
        rx_i_data = '0; rx_q_data = '0; rx_loc_boc = 1'b0; rx_loc_prn = 1'b0;
        rx_prn_sop = 1'b0; rx_prn_eop = 1'b0;
        useConst = 1; constI = 10; constQ = -3; prnMode = 0; prnTog = 0;
        bocFollowsPrn = 0; bocSelRand = 0; enJitter = 0;
        modelReset();
        repeat (3) @(negedge clk);
        resetChecks("reset");
        rst_n = 1'b1;

        // Constant samples against an all-zero PRN replica
        rx_corr_en = 1'b1;
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        repeat (3) runPeriod(4092, 0);

        // Alternating replica cancels a constant sample, on both replica paths
        prnMode = 1; prnTog = 0;
        repeat (2) runPeriod(4092, 0);
        rx_boc_sel = 1'b1; bocFollowsPrn = 1; prnTog = 0;
        runPeriod(4092, 0);
        runPeriod(20, 0);

        // Saturation then clean recovery
        rx_boc_sel = 1'b0; bocFollowsPrn = 0; prnMode = 0;
        constI = 127; constQ = 0;
        runPeriod(4092, 0);
        constI = 1;
        runPeriod(4092, 0);
        runPeriod(20, 0);

        // Multi-period integration and the zero-length case
        rx_int_len = LW'(3);
        repeat (5) runPeriod(50, 0);
        rx_int_len = LW'(0);
        repeat (3) runPeriod(50, 0);
        rx_int_len = LW'(2);

        // Enable dropped mid-period, then restarted
        runPeriod(30, 0);
        applyStimulus(1, 0);
        repeat (12) applyStimulus(0, 0);
        rx_corr_en = 1'b0;
        repeat (4) applyStimulus(0, 0);
        rx_corr_en = 1'b1;
        rx_int_len = LW'(1);
        repeat (5) applyStimulus(0, 0);
        repeat (3) runPeriod(40, 0);

        // Missing eop makes the sequence error sticky
        runPeriod(40, 1);
        repeat (3) runPeriod(40, 0);

        // Fully random traffic, including enable glitches
        useConst = 0; prnMode = 2; bocSelRand = 1; enJitter = 1;
        for (int p = 0; p < 60; p++) begin
            rx_int_len = LW'($urandom_range(0, 3));
            runPeriod($urandom_range(4, 250), $urandom_range(0, 7) == 0);
        end
        enJitter = 0; rx_corr_en = 1'b1;

        // Asynchronous reset in the middle of an integration
        repeat (3) runPeriod(30, 0);
        applyStimulus(1, 0);
        repeat (10) applyStimulus(0, 0);
        #2 rst_n = 1'b0;
        #1 resetChecks("async_rst");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        resetChecks("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/boc_corr_accum.md
Name: boc_corr_accum

Overview:
- Integrate-and-dump correlator directly downstream of the BOC/PRN replica generator.
- Wipes the local replica chip (BOC or plain PRN) off baseband I/Q samples every clock.
- Accumulates the wiped samples over an integer number of code periods, delimited by the generator's start-of-period pulse.
- Presents registered I/Q sums to the tracking/acquisition loop with a one-cycle valid strobe.

Parameters:
- DATA_WIDTH, 8, signed width of rx_i_data/rx_q_data.
- ACC_WIDTH, 24, signed accumulator and output width.
- LEN_WIDTH, 5, width of rx_int_len.

Ports:
- rx_clk  in  1  sample clock, shared with the replica generator.
- rx_rst  in  1  asynchronous reset, active-low.
- rx_corr_en  in  1  correlation enable; 0 forces IDLE.
- rx_boc_sel  in  1  1 = use rx_loc_boc, 0 = use rx_loc_prn as replica.
- rx_int_len  in  LEN_WIDTH  code periods per dump; 0 treated as 1.
- rx_i_data  in  DATA_WIDTH  signed in-phase sample.
- rx_q_data  in  DATA_WIDTH  signed quadrature sample.
- rx_loc_boc  in  1  BOC replica chip (0 → +1, 1 → −1).
- rx_loc_prn  in  1  PRN replica chip (0 → +1, 1 → −1).
- rx_prn_sop  in  1  start-of-code-period pulse, cycle-aligned with the replica.
- rx_prn_eop  in  1  end-of-code-period pulse.
- tx_i_acc  out  ACC_WIDTH  dumped I sum.
- tx_q_acc  out  ACC_WIDTH  dumped Q sum.
- tx_acc_valid  out  1  one-cycle pulse when the tx_*_acc values update.
- tx_acc_ovf  out  1  saturation occurred in the integration just dumped.
- tx_seq_err  out  1  sticky: sop arrived without a preceding eop in the period.
- tx_dump_cnt  out  16  count of dumps since enable; wraps.

Behaviour:
- Reset (rx_rst=0, async): all outputs 0, accumulators 0, state IDLE, period counter 0.
- Replica selection: r = rx_boc_sel ? rx_loc_boc : rx_loc_prn.
- Wipe-off: product = r ? −sample : +sample.
  - Sign-extend to DATA_WIDTH+1 bits before negation, so −(−128) = +128.
- Sample/replica pairing: the sample and replica of the same cycle are multiplied; no internal delay on either.
- States:
  - IDLE: accumulators held at 0. rx_corr_en=1 → WAIT_SOP next cycle.
  - WAIT_SOP: on rx_prn_sop=1, load acc = product of that cycle, period_cnt=1, latch len = max(rx_int_len,1), clear the eop_seen and ovf flags → ACCUM.
  - ACCUM, no sop: acc += product, saturating at ±(2^(ACC_WIDTH-1)−1 / −2^(ACC_WIDTH-1)). Any saturation sets the internal ovf flag. rx_prn_eop sets eop_seen.
  - ACCUM, sop with period_cnt < len: continue accumulating; include the sop-cycle product; period_cnt++.
  - ACCUM, sop with period_cnt == len (dump):
    - Next cycle: tx_i_acc/tx_q_acc = sums excluding the sop-cycle product, tx_acc_ovf = ovf, tx_acc_valid=1, tx_dump_cnt++.
    - Same edge: acc reloaded with the sop-cycle product, period_cnt=1, len re-latched. No sample is lost or double-counted.
  - Latency: 1 cycle from the dump sop to tx_acc_valid. Outputs then hold until the next dump.
- Any sop in ACCUM with eop_seen=0 sets tx_seq_err (sticky until reset or rx_corr_en falling); eop_seen clears on every sop.
- rx_corr_en=0 in any state: → IDLE next cycle, partial integration discarded, no tx_acc_valid; tx_*_acc/tx_acc_ovf keep last dumped values; tx_dump_cnt and tx_seq_err cleared.
- rx_int_len changes mid-integration take effect only at the next integration start.
- Simultaneous sop and eop on the same cycle: treat eop as belonging to the ending period (eop_seen satisfied), then apply sop rules.
- rx_boc_sel changes are honoured per cycle; no glitch protection is required.

Test Plan:
- Constant I=+10, Q=−3, prn=0, boc_sel=0, sop every 4092 cycles (eop at 4091), len=1 → tx_i_acc=40920, tx_q_acc=−12276, one valid per period, seq_err=0.
- Same stimulus, prn toggling every cycle starting at 0 → tx_i_acc=0, tx_q_acc=0; with boc_sel=1, boc=prn^1 → tx_i_acc=0.
- I=+127, ACC_WIDTH=16, len=1, period 4092 → tx_i_acc=32767, tx_acc_ovf=1; the next period with I=+1 → 4092, ovf=0.
- len=3, I=+1 constant → first valid 1 cycle after the 4th sop, value 12276; len=0 → 4092 every period.
- Deassert rx_corr_en mid-period, reassert → no valid until the second sop after reassert; tx_dump_cnt restarts at 1.
- Drop one eop pulse → tx_seq_err=1 after the following sop and stays 1; assert rx_rst low mid-ACCUM → all outputs 0 immediately.
